// File: rtl/rv_mem_resp_if.sv
// rv_mem_resp_if: request/response bundle between the core's data port and rv_mem_resp.
// Latency: none, wires only.
// Backpressure: master holds req/memrw/addr/wdata stable until ack; the slave stalls via busy.
// Ports: req, memrw, addr, wdata (master -> slave); rdata, ack, err, busy (slave -> master).
interface rv_mem_resp_if;
  logic        req;
  logic        memrw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, memrw, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, memrw, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/rv_mem_resp.sv
// rv_mem_resp: word-addressed memory responder with programmable wait states and error flag.
// Latency: req sampled in IDLE cycle N gives a one-cycle ack in cycle N+1+LATENCY.
// Backpressure: one request in flight; req is ignored while busy, requester holds it until ack.
// Ports: clk_i, rst_ni (synchronous, active-low); bus (slave modport of rv_mem_resp_if).
module rv_mem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  rv_mem_resp_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        memrw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;

  // Array contents survive reset, so it has no reset branch.
  logic [31:0] mem_q [DEPTH];

  // Request fields used for the access on the edge entering RESP. With
  // LATENCY = 0 that edge is also the capture edge, so the live inputs are
  // used in IDLE; otherwise the captured copies are.
  logic             in_idle;
  logic             acc_memrw;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_legal;
  logic [IDX_W-1:0] acc_idx;
  logic             enter_resp;

  always_comb begin
    in_idle    = (state_q == S_IDLE);
    acc_memrw  = in_idle ? bus.memrw : memrw_q;
    acc_addr   = in_idle ? bus.addr  : addr_q;
    acc_wdata  = in_idle ? bus.wdata : wdata_q;
    acc_legal  = (acc_addr[1:0] == 2'b00) && (acc_addr[31:2] < 30'(DEPTH));
    acc_idx    = acc_addr[IDX_W+1:2];
    enter_resp = (in_idle && bus.req && (LATENCY == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == 4'd1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      memrw_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            memrw_q <= bus.memrw;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= 4'(LATENCY);
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Response is resolved on the edge entering RESP; a legal write
      // leaves rdata holding the previous read result.
      if (enter_resp) begin
        ack_q <= 1'b1;
        err_q <= !acc_legal;
        if (!acc_legal) begin
          rdata_q <= 32'h0;
        end else if (!acc_memrw) begin
          rdata_q <= mem_q[acc_idx];
        end
      end
    end
  end

  // Gated with rst_ni so a reset on the WAIT->RESP edge aborts the write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && acc_legal && acc_memrw) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rv_mem_resp.sv
// tb_rv_mem_resp: directed checks of rv_mem_resp at LATENCY 0 and 2, scoreboard-checked responses.
// Latency: expected ack cycle is stored with each queued response and compared on arrival.
// Backpressure: requester holds req until ack and drops it in the ack cycle.
module tb_rv_mem_resp;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  // Index 0: LATENCY = 0 instance, index 1: LATENCY = 2 instance.
  int          lat [2];
  logic        req_d   [2];
  logic        memrw_d [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];
  logic [31:0] rdata_w [2];

  exp_t q0[$];
  exp_t q1[$];

  rv_mem_resp_if bus0 ();
  rv_mem_resp_if bus1 ();

  assign bus0.req   = req_d[0];
  assign bus0.memrw = memrw_d[0];
  assign bus0.addr  = addr_d[0];
  assign bus0.wdata = wdata_d[0];
  assign bus1.req   = req_d[1];
  assign bus1.memrw = memrw_d[1];
  assign bus1.addr  = addr_d[1];
  assign bus1.wdata = wdata_d[1];

  assign ack_w[0]   = bus0.ack;
  assign err_w[0]   = bus0.err;
  assign busy_w[0]  = bus0.busy;
  assign rdata_w[0] = bus0.rdata;
  assign ack_w[1]   = bus1.ack;
  assign err_w[1]   = bus1.err;
  assign busy_w[1]  = bus1.busy;
  assign rdata_w[1] = bus1.rdata;

  rv_mem_resp #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst),
    .bus    (bus0)
  );

  rv_mem_resp #(.DEPTH(256), .LATENCY(2)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_resp(input int d, input exp_t e);
    check($sformatf("dut%0d_err", d), {31'b0, err_w[d]}, {31'b0, e.err});
    check($sformatf("dut%0d_rdata", d), rdata_w[d], e.rdata);
    check($sformatf("dut%0d_ack_cycle", d), cyc, e.cyc);
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every ack pops one expected response; err must never appear without ack.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ack_w[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_ack: got ack=1, expected no ack (cycle %0d)", d, cyc);
          end else if (d == 0) begin
            cmp_resp(0, q0.pop_front());
          end else begin
            cmp_resp(1, q1.pop_front());
          end
        end else begin
          check($sformatf("dut%0d_err_without_ack", d), {31'b0, err_w[d]}, 32'd0);
        end
      end
    end
  end

  // One request, held until ack; busy checked every in-flight cycle.
  task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    bit   seen;
    @(negedge clk);
    req_d[d]   = 1'b1;
    memrw_d[d] = wr;
    addr_d[d]  = a;
    wdata_d[d] = wd;
    e.err   = e_err;
    e.rdata = e_rd;
    e.cyc   = cyc + 1 + lat[d];
    push_exp(d, e);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      check($sformatf("dut%0d_busy_inflight", d), {31'b0, busy_w[d]}, 32'd1);
      if (ack_w[d]) seen = 1'b1;
    end
    check($sformatf("dut%0d_ack_seen", d), {31'b0, seen}, 32'd1);
    req_d[d] = 1'b0;
    @(negedge clk);
    check($sformatf("dut%0d_busy_after_ack", d), {31'b0, busy_w[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   acks;
    n_cmp = 0;
    n_bad = 0;
    lat[0] = 0;
    lat[1] = 2;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_d[d]   = 1'b0;
      memrw_d[d] = 1'b0;
      addr_d[d]  = 32'h0;
      wdata_d[d] = 32'h0;
    end

    // Reset held for two edges, then released.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d_reset_ack", d),   {31'b0, ack_w[d]},  32'd0);
      check($sformatf("dut%0d_reset_err", d),   {31'b0, err_w[d]},  32'd0);
      check($sformatf("dut%0d_reset_busy", d),  {31'b0, busy_w[d]}, 32'd0);
      check($sformatf("dut%0d_reset_rdata", d), rdata_w[d],         32'd0);
    end

    // LATENCY = 2 instance.
    txn(1, 1'b1, 32'h10,  32'hCAFEF00D, 1'b0, 32'h0);        // write, rdata still reset value
    txn(1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hCAFEF00D); // read back
    txn(1, 1'b1, 32'h13,  32'h12345678, 1'b1, 32'h0);        // misaligned write
    txn(1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hCAFEF00D); // array untouched
    txn(1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0);        // out of range read

    // req toggled and addr changed while busy: captured read of 0x10 completes once.
    @(negedge clk);
    req_d[1] = 1'b1; memrw_d[1] = 1'b0; addr_d[1] = 32'h10;
    e.err = 1'b0; e.rdata = 32'hCAFEF00D; e.cyc = cyc + 3;
    push_exp(1, e);
    @(negedge clk);
    req_d[1] = 1'b0; memrw_d[1] = 1'b1; addr_d[1] = 32'h20;
    @(negedge clk);
    req_d[1] = 1'b1; addr_d[1] = 32'h24;
    @(negedge clk);
    check("busytime_ack", {31'b0, ack_w[1]}, 32'd1);
    req_d[1] = 1'b0; memrw_d[1] = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[1]) acks++;
    end
    check("busytime_extra_acks", acks, 32'd0);

    txn(1, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'hCAFEF00D); // legal write keeps old rdata

    // LATENCY = 0 instance.
    txn(0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0);
    @(negedge clk);
    req_d[0] = 1'b1; memrw_d[0] = 1'b0; addr_d[0] = 32'h10;
    e.err = 1'b0; e.rdata = 32'hCAFEF00D; e.cyc = cyc + 1;
    push_exp(0, e);
    e.cyc = e.cyc + 2;
    push_exp(0, e);
    acks = 0;
    for (int k = 0; k < 20 && acks < 2; k++) begin
      @(negedge clk);
      if (ack_w[0]) acks++;
    end
    req_d[0] = 1'b0;
    check("lat0_two_acks", acks, 32'd2);
    @(negedge clk);
    check("lat0_busy_after", {31'b0, busy_w[0]}, 32'd0);

    // Reset in the first WAIT cycle aborts a write of 0x22222222 to 0x20.
    @(negedge clk);
    req_d[1] = 1'b1; memrw_d[1] = 1'b1; addr_d[1] = 32'h20; wdata_d[1] = 32'h22222222;
    @(negedge clk);
    check("rstmid_busy_in_wait", {31'b0, busy_w[1]}, 32'd1);
    rst = 1'b0;
    req_d[1] = 1'b0;
    @(negedge clk);
    check("rstmid_busy_cleared", {31'b0, busy_w[1]}, 32'd0);
    check("rstmid_no_ack",       {31'b0, ack_w[1]},  32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_no_ack_after", {31'b0, ack_w[1]},  32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111);

    repeat (3) @(negedge clk);
    check("sb_dut0_drained", q0.size(), 32'd0);
    check("sb_dut1_drained", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_mem_resp.md
# rv_mem_resp

Word-addressed memory responder for the multicycle RISC-V core. It accepts one request at a time over a level `req` / single-cycle `ack` handshake and stalls for a programmable number of wait states. It then performs the read or write on an internal register array and returns registered read data with an error flag. It sits on the memory side of the control plane's `memrw` strobe and is the target the core addresses for data loads and stores.

## Interface
- `DEPTH`, 256 — number of 32-bit words in the array; power of two, 4..4096.
- `LATENCY`, 2 — wait-state cycles inserted before `ack`; legal range 0..15.
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `rst`  in  1  — reset; synchronous, active-low.
- `req`  in  1  — request valid, level signal. Requester holds `req`, `memrw`, `addr` and `wdata` stable until `ack`.
- `memrw`  in  1  — 1 = write, 0 = read (same polarity as the core's `memrw`).
- `addr`  in  32  — byte address; must be word-aligned.
- `wdata`  in  32  — write data.
- `rdata`  out  32  — registered read data; valid in the `ack` cycle and held until the next `ack`.
- `ack`  out  1  — one-cycle completion pulse.
- `err`  out  1  — qualifies `ack`; high only in an `ack` cycle whose request was illegal.
- `busy`  out  1  — high while a request is in flight (any state other than IDLE).

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: `ack` cycle.
- IDLE → WAIT (or directly → RESP when `LATENCY` = 0) on a cycle with `req` = 1.
  - That edge captures `memrw`, `addr` and `wdata` into internal registers.
  - The same edge loads the wait counter with `LATENCY`.
- WAIT: the counter decrements every cycle. WAIT → RESP on the edge where the counter equals 1.
- RESP → IDLE unconditionally. `ack` = 1 in RESP only.
- Illegal request: `addr[1:0]` ≠ 0, or the word index `addr[31:2]` ≥ `DEPTH`. The check uses the captured address.
- The array access happens on the edge entering RESP, using the captured index:
  - Legal write: array[index] ← captured `wdata`. `rdata` is unchanged.
  - Legal read: `rdata` ← array[index].
  - Illegal request: `err` is set for the RESP cycle, the array is untouched, and `rdata` ← 0 for both reads and writes.
- `req` is sampled only in IDLE. Changes on `req` while `busy` = 1 are ignored.
- If `req` is still 1 in the IDLE cycle after `ack`, it starts a new transaction. The requester must drop `req` on the edge that ends the `ack` cycle if it has no further request.
- Read-after-write: a read issued after a write's `ack` returns the written value.
- The array contents are not reset. They are preserved across reset.

## Timing
- Reset (`rst` = 0 at a rising edge) sets:
  - state = IDLE, counter = 0
  - `ack` = 0, `err` = 0, `busy` = 0
  - `rdata` = 32'h0000_0000
- Reset mid-transaction:
  - Reset in WAIT aborts the request: no array write, no `ack`.
  - Reset asserted in the RESP cycle: the access has already completed at RESP entry. `ack` is still visible in that cycle, and all outputs clear on the next edge.
- Latency: if `req` = 1 in IDLE cycle N, then `ack` = 1 in cycle N+1+`LATENCY` exactly, and `busy` = 1 in cycles N+1 … N+1+`LATENCY`.
- Throughput: at most one transaction per `LATENCY`+2 cycles. Back-to-back requests use cycle N+2+`LATENCY` as the next IDLE cycle.
- All outputs are registered or decoded from the state register only. There is no combinational path from the inputs to the outputs.

## Test plan
- **Reset:** hold `rst` = 0 for 2 cycles, release → `ack` = 0, `err` = 0, `busy` = 0, `rdata` = 0. IDLE is reached in the first cycle after release.
- **Write then read, `LATENCY` = 2:**
  - `req` = 1, `memrw` = 1, `addr` = 0x10, `wdata` = 0xCAFEF00D in cycle N → `busy` = 1 in N+1..N+3, `ack` = 1 in N+3 only, `err` = 0.
  - Then a read of 0x10 → `rdata` = 0xCAFEF00D in its `ack` cycle, 3 cycles after `req`.
- **`LATENCY` = 0:** read of 0x10 → `ack` and valid `rdata` in cycle N+1. `req` held through the next cycle starts a second read, acked in N+3.
- **Illegal addresses (`DEPTH` = 256):**
  - Write to 0x13 (misaligned) with `wdata` 0x12345678 → `ack` with `err` = 1, `rdata` = 0. A following read of 0x10 still returns 0xCAFEF00D.
  - Read of 0x400 (out of range) → `err` = 1, `rdata` = 0.
- **Busy-time request:** toggle `req` and change `addr` during WAIT → the in-flight transaction completes with its captured `addr`, and exactly one `ack` is produced.
- **Reset mid-write:**
  - Setup: 0x20 holds 0x11111111.
  - Stimulus: start a write of 0x22222222 to 0x20, then assert `rst` = 0 in the first WAIT cycle.
  - Response: no `ack`, and `busy` = 0 after the reset edge. A subsequent read of 0x20 returns 0x11111111.
